rst_seq_ctrl: RTL

//  Reset sequencer/arbiter sitting after the external reset synchroniser.

---
 rtl/rst_seq_ctrl_if.sv | 33 +++
 rtl/rst_seq_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl_if.sv
// rtl/rst_seq_ctrl_if.sv - request/response bundle between reset sources and the reset sequencer
interface rst_seq_ctrl_if;
    logic       jtag_req_i;
    logic       wdg_req_i;
    logic       sw_req_i;
    logic       clr_cause_i;
    logic       periph_rst_n_o;
    logic       core_rst_n_o;
    logic       busy_o;
    logic [3:0] rst_cause_o;

    modport master (
        output jtag_req_i,
        output wdg_req_i,
        output sw_req_i,
        output clr_cause_i,
        input  periph_rst_n_o,
        input  core_rst_n_o,
        input  busy_o,
        input  rst_cause_o
    );

    modport slave (
        input  jtag_req_i,
        input  wdg_req_i,
        input  sw_req_i,
        input  clr_cause_i,
        output periph_rst_n_o,
        output core_rst_n_o,
        output busy_o,
        output rst_cause_o
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - staged reset sequencer, optional cause record under RST_SEQ_CAUSE_EN
module rst_seq_ctrl #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int CW          = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    rst_seq_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_PERIPH = 2'd1,
        ST_RUN    = 2'd2,
        ST_CHOLD  = 2'd3
    } state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_full_req;
    logic            r_periph_rst_n;
    logic            r_core_rst_n;
    logic            r_busy;

    assign w_full_req = bus.wdg_req_i | bus.sw_req_i;
    // Counter never wraps: it parks at all-ones if a compare is somehow missed.
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

    // Next-state and counter: full-system requests beat jtag, jtag freezes the count at 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_HOLD: begin
                if (w_full_req || bus.jtag_req_i) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_PERIPH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_PERIPH: begin
                if (w_full_req) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else if (bus.jtag_req_i) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == GAP_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = '0;
                if (w_full_req) begin
                    w_state_nxt = ST_HOLD;
                end else if (bus.jtag_req_i) begin
                    w_state_nxt = ST_CHOLD;
                end
            end
            ST_CHOLD: begin
                if (w_full_req) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else if (bus.jtag_req_i) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and reset outputs all registered from the next state, so a
    // request seen at one edge is reflected on the outputs right after that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_HOLD;
            r_cnt          <= '0;
            r_periph_rst_n <= 1'b0;
            r_core_rst_n   <= 1'b0;
            r_busy         <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_periph_rst_n <= (w_state_nxt != ST_HOLD);
            r_core_rst_n   <= (w_state_nxt == ST_RUN);
            r_busy         <= (w_state_nxt != ST_RUN);
        end
    end

    assign bus.periph_rst_n_o = r_periph_rst_n;
    assign bus.core_rst_n_o   = r_core_rst_n;
    assign bus.busy_o         = r_busy;

`ifdef RST_SEQ_CAUSE_EN
    logic [3:0] r_cause;

    // Sticky cause {sw, wdg, jtag, por}: new requests are ORed in after any clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cause <= 4'b0001;
        end else begin
            r_cause <= (bus.clr_cause_i ? 4'b0000 : r_cause)
                     | {bus.sw_req_i, bus.wdg_req_i, bus.jtag_req_i, 1'b0};
        end
    end

    assign bus.rst_cause_o = r_cause;
`else
    logic w_unused_clr;

    assign w_unused_clr    = bus.clr_cause_i;
    assign bus.rst_cause_o = 4'b0000;
`endif

endmodule
